// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store stage: FSM encoding, default widths
// and the saturation limit used by the access counters.
package mem_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned ADDR_WIDTH_DEF  = 5;
    localparam int unsigned REG_WIDTH_DEF   = 3;
    localparam int unsigned MEM_DEPTH_DEF   = 32;
    localparam int unsigned COUNT_WIDTH     = 8;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and the data memory.
// Groups: request handshake (req_*), memory strobes/address/data, writeback
// (wb_*), completion pulse and access counters.
// slave  : the load/store unit side.
// master : the surrounding system (execute stage + memory) side.
// With MEM_ACCESS_RANGE_CHECK_EN defined an addr_err flag is added.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic [REG_WIDTH-1:0]   req_rd;

    logic                   signal_memread;
    logic                   signal_memwrite;
    logic [ADDR_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]  data_to_write;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    logic                   wb_valid;
    logic [REG_WIDTH-1:0]   wb_rd;
    logic [DATA_WIDTH-1:0]  wb_data;
    logic                   done;
    logic [COUNT_WIDTH-1:0] load_count;
    logic [COUNT_WIDTH-1:0] store_count;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    logic                   addr_err;
`endif

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_rd, mem_rdata,
        output req_ready, signal_memread, signal_memwrite, address, data_to_write,
        output wb_valid, wb_rd, wb_data, done, load_count, store_count
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        , output addr_err
`endif
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_rd, mem_rdata,
        input  req_ready, signal_memread, signal_memwrite, address, data_to_write,
        input  wb_valid, wb_rd, wb_data, done, load_count, store_count
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        , input addr_err
`endif
    );

endinterface

// File: rtl/mem_access_unit_sat_counter8.sv
// 8-bit event counter that sticks at COUNT_MAX instead of wrapping.
// Ports: clock, clear_n (sync active-low), i_inc (count enable), o_count.
module sat_counter8
    import mem_pkg::*;
(
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   i_inc,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != COUNT_MAX)) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage in front of the data memory. Takes one request at a time,
// drives the memory for exactly one ACCESS cycle, returns load data through a
// one-cycle WB pulse and flags every completed access with done.
// Ports: clock, clear_n (sync active-low), bus (mem_access_unit_if.slave).
// Optional: MEM_ACCESS_RANGE_CHECK_EN adds the MEM_DEPTH parameter and addr_err;
// out-of-range requests then suppress the strobes and complete with addr_err.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
`endif
    parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF
)(
    input  logic clock,
    input  logic clear_n,
    mem_access_unit_if.slave bus
);

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [REG_WIDTH-1:0]  r_rd;
    logic                  r_wb_valid;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_in_access;
    logic                  w_oob;
    logic                  w_strobe_en;
    logic                  w_load_inc;
    logic                  w_store_inc;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    logic                  r_addr_err;

    // Extra bit so MEM_DEPTH equal to 2**ADDR_WIDTH is representable.
    assign w_oob = ({1'b0, r_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH));
`else
    assign w_oob = 1'b0;
`endif

    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_in_access = (r_state == ST_ACCESS);
    // Gated with clear_n so a reset cycle can never write memory.
    assign w_strobe_en = w_in_access && clear_n && !w_oob;

    // State register.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (bus.req_valid) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = (!r_write && !w_oob) ? ST_WB : ST_IDLE;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, load capture and completion pulses.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_done     <= 1'b0;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            r_addr_err <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_rd    <= bus.req_rd;
            end
            // Every ACCESS ends in completion: store/error now, load in WB.
            r_done     <= w_in_access;
            r_wb_valid <= w_in_access && !r_write && !w_oob;
            if (w_in_access && !r_write && !w_oob) begin
                r_wb_data <= bus.mem_rdata;
            end
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            r_addr_err <= w_in_access && w_oob;
`endif
        end
    end

    assign w_store_inc = w_in_access && r_write && !w_oob;
    assign w_load_inc  = (r_state == ST_WB);

    sat_counter8 u_load_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .i_inc   (w_load_inc),
        .o_count (bus.load_count)
    );

    sat_counter8 u_store_cnt (
        .clock   (clock),
        .clear_n (clear_n),
        .i_inc   (w_store_inc),
        .o_count (bus.store_count)
    );

    assign bus.req_ready       = (r_state == ST_IDLE);
    assign bus.signal_memread  = w_strobe_en && !r_write;
    assign bus.signal_memwrite = w_strobe_en && r_write;
    assign bus.address         = r_addr;
    assign bus.data_to_write   = r_wdata;
    assign bus.wb_valid        = r_wb_valid;
    assign bus.wb_rd           = r_rd;
    assign bus.wb_data         = r_wb_data;
    assign bus.done            = r_done;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign bus.addr_err        = r_addr_err;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32x8 memory, a
// reference memory image and scoreboards for stores and writebacks.
module tb_mem_access_unit;

    logic clock;
    logic clear_n;

    mem_access_unit_if bus ();

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    mem_access_unit #(.MEM_DEPTH(24)) dut (
`else
    mem_access_unit dut (
`endif
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]  mem     [32];
    logic [7:0]  ref_mem [32];
    logic [12:0] st_q [$];   // {addr, data} of accepted stores
    logic [10:0] wb_q [$];   // {rd, data} of accepted loads
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_acc = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.signal_memwrite) mem[bus.address] <= bus.data_to_write;
    end
    assign bus.mem_rdata = mem[bus.address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clock) begin
        logic [12:0] s;
        logic [10:0] w;
        if (bus.signal_memwrite === 1'b1) begin
            if (st_q.size() == 0) check("unexpected_memwrite", 1, 0);
            else begin
                s = st_q.pop_front();
                check("st_addr", 32'(bus.address), 32'(s[12:8]));
                check("st_data", 32'(bus.data_to_write), 32'(s[7:0]));
            end
        end
        if (bus.wb_valid === 1'b1) begin
            if (wb_q.size() == 0) check("unexpected_wb", 1, 0);
            else begin
                w = wb_q.pop_front();
                check("wb_rd", 32'(bus.wb_rd), 32'(w[10:8]));
                check("wb_data", 32'(bus.wb_data), 32'(w[7:0]));
                check("wb_done", 32'(bus.done), 1);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Present a request and hold it until accepted; push expected results.
    task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d,
                         input logic [2:0] rd, input bit drop);
        logic rdy;
        bit   ok = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_rd    = rd;
        for (int i = 0; i < 20 && !ok; i++) begin
            rdy = bus.req_ready;
            step();
            if (rdy === 1'b1) ok = 1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        else begin
            last_acc = cyc;
            if (w) begin
                st_q.push_back({a, d});
                ref_mem[a] = d;
            end else begin
                wb_q.push_back({rd, ref_mem[a]});
            end
        end
        if (drop) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (st_q.size() == 0 && wb_q.size() == 0 && bus.req_ready === 1'b1) ok = 1;
            else step();
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 8'(i);
            ref_mem[i] = 8'(i);
        end
        mem[17]     = 8'hFF;
        ref_mem[17] = 8'hFF;

        // Reset with a store request pending: nothing may be written.
        clear_n       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 5'd0;
        bus.req_wdata = 8'h77;
        bus.req_rd    = 3'd0;
        step();
        check("rst_memwrite", 32'(bus.signal_memwrite), 0);
        check("rst_memread", 32'(bus.signal_memread), 0);
        step();
        clear_n       = 1'b1;
        bus.req_valid = 1'b0;
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_address", 32'(bus.address), 0);
        check("rst_wdata", 32'(bus.data_to_write), 0);
        check("rst_wb_data", 32'(bus.wb_data), 0);
        check("rst_wb_rd", 32'(bus.wb_rd), 0);
        check("rst_counts", 32'({bus.load_count, bus.store_count}), 0);
        step();
        check("idle_no_accept", 32'(bus.req_ready), 1);

        // Load addr 5 into r3.
        issue(1'b0, 5'd5, 8'h00, 3'd3, 1);
        check("ld_memread", 32'(bus.signal_memread), 1);
        check("ld_address", 32'(bus.address), 5);
        check("ld_ready_access", 32'(bus.req_ready), 0);
        step();
        check("ld_wb_valid", 32'(bus.wb_valid), 1);
        check("ld_wb_data", 32'(bus.wb_data), 8'h05);
        check("ld_ready_wb", 32'(bus.req_ready), 0);
        check("ld_memread_off", 32'(bus.signal_memread), 0);
        step();
        check("ld_count", 32'(bus.load_count), 1);
        check("ld_done_off", 32'(bus.done), 0);
        check("ld_ready_back", 32'(bus.req_ready), 1);

        // Store then load of the same address.
        issue(1'b1, 5'd17, 8'hA5, 3'd0, 1);
        check("st_memwrite", 32'(bus.signal_memwrite), 1);
        check("st_data_out", 32'(bus.data_to_write), 8'hA5);
        step();
        check("st_done", 32'(bus.done), 1);
        check("st_count", 32'(bus.store_count), 1);
        check("st_no_wb", 32'(bus.wb_valid), 0);
        issue(1'b0, 5'd17, 8'h00, 3'd5, 1);
        wait_idle();
        check("mem17", 32'(mem[17]), 8'hA5);

        // Four loads with req_valid held high: accepts every 3 cycles.
        issue(1'b0, 5'd1, 8'h00, 3'd0, 0);
        prev = last_acc;
        issue(1'b0, 5'd9, 8'h00, 3'd1, 0);
        check("b2b_gap1", 32'(last_acc - prev), 3);
        prev = last_acc;
        issue(1'b0, 5'd31, 8'h00, 3'd2, 0);
        check("b2b_gap2", 32'(last_acc - prev), 3);
        prev = last_acc;
        issue(1'b0, 5'd17, 8'h00, 3'd3, 1);
        check("b2b_gap3", 32'(last_acc - prev), 3);
        wait_idle();
        check("b2b_load_count", 32'(bus.load_count), 6);

        // Reset lands in the ACCESS cycle of a store to addr 2.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 5'd2;
        bus.req_wdata = 8'h3C;
        check("abort_ready", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        clear_n       = 1'b0;
        #1;
        check("abort_memwrite", 32'(bus.signal_memwrite), 0);
        step();
        clear_n = 1'b1;
        check("abort_idle", 32'(bus.req_ready), 1);
        check("abort_counts", 32'({bus.load_count, bus.store_count}), 0);
        issue(1'b0, 5'd2, 8'h00, 3'd4, 1);
        wait_idle();
        check("abort_mem2", 32'(mem[2]), 8'h02);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
        // Out-of-range store: no strobe, addr_err + done pulse, no count.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 5'd30;
        bus.req_wdata = 8'h11;
        step();
        bus.req_valid = 1'b0;
        check("oob_memwrite", 32'(bus.signal_memwrite), 0);
        step();
        check("oob_addr_err", 32'(bus.addr_err), 1);
        check("oob_done", 32'(bus.done), 1);
        check("oob_count", 32'(bus.store_count), 0);
        step();
        check("oob_err_off", 32'(bus.addr_err), 0);
`endif

        // 260 stores saturate store_count.
        for (int i = 0; i < 260; i++) begin
            issue(1'b1, 5'(i % 24), 8'($urandom_range(0, 255)), 3'd0, 1);
            if (i == 254) begin
                step();
                check("sat_254", 32'(bus.store_count), 255);
            end
        end
        wait_idle();
        check("sat_store_count", 32'(bus.store_count), 255);
        check("sat_load_count", 32'(bus.load_count), 1);

        // Read back a few stored words, including the top address.
        issue(1'b0, 5'd7, 8'h00, 3'd6, 1);
        issue(1'b0, 5'd23, 8'h00, 3'd7, 1);
        issue(1'b0, 5'd31, 8'h00, 3'd1, 1);
        wait_idle();
        step();
        check("final_load_count", 32'(bus.load_count), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
